riscv_smartv_ctx_loader: RTL and testbench
==========================================

// Module: riscv_smartv_ctx_loader
//
// PURPOSE
// Configures the SMART-V protection unit on a task switch.
// - Fetches the task's region descriptor from a table in memory over a dedicated single-outstanding read port:
//   code/data/lib bounds, peripheral mask, bit-band mask and bit-band registers.
// - Loads the words into shadow registers, then commits them atomically to the pmp_addr vector consumed by riscv_smartv.
// - The protection unit therefore never sees a half-written context. The core is stalled while a load is in flight.
//
// PARAMETERS
// N_PMP_ENTRIES    16  width of pmp_addr_o vector (entries)
// N_CTX_WORDS      10  descriptor words loaded per switch; they map to entries 0..N_CTX_WORDS-1 (CSR 3B0..3B9)
// TASK_ID_W        4   task id width (up to 16 tasks)
// DESC_STRIDE_LOG2 6   log2 of bytes per descriptor (64 B); requires 4*N_CTX_WORDS <= 2**DESC_STRIDE_LOG2
//
// PORTS
// clk             in   1                   clock
// rst_n           in   1                   async active-low reset
// switch_req_i    in   1                   1-cycle pulse: load context task_id_i (sampled in IDLE only)
// task_id_i       in   TASK_ID_W           task to load
// table_base_i    in   32                  descriptor table base, word aligned
// busy_o          out  1                   load in progress
// core_stall_o    out  1                   = busy_o; holds the pipeline
// done_o          out  1                   1-cycle pulse: context committed
// err_o           out  1                   1-cycle pulse: load aborted on bus error
// mem_req_o       out  1                   read request
// mem_addr_o      out  32                  read address
// mem_gnt_i       in   1                   request accepted
// mem_rvalid_i    in   1                   read data valid
// mem_rdata_i     in   32                  read data
// mem_err_i       in   1                   qualifies mem_rvalid_i as bus error
// csr_we_i        in   1                   M-mode CSR write to one entry
// csr_idx_i       in   $clog2(N_PMP_ENTRIES) entry index
// csr_wdata_i     in   32                  CSR write data
// pmp_addr_o      out  N_PMP_ENTRIES x 32  active configuration to riscv_smartv
//
// BEHAVIOUR
// - Reset (async): every pmp_addr_o entry = 0; busy_o, done_o, err_o, mem_req_o = 0; mem_addr_o = 0; FSM = IDLE; word counter k = 0.
// - FSM states: IDLE, REQ, WAIT, COMMIT.
//   - IDLE: on switch_req_i, latch base = table_base_i + (task_id_i << DESC_STRIDE_LOG2), k = 0 -> REQ. busy_o rises next cycle.
//   - REQ: mem_req_o = 1, mem_addr_o = base + 4*k, both held stable until mem_gnt_i. On gnt -> WAIT.
//   - WAIT: one request outstanding, no new request is issued.
//     - mem_rvalid_i & !mem_err_i: shadow[k] = mem_rdata_i. If k == N_CTX_WORDS-1 -> COMMIT, else k++ -> REQ.
//     - mem_rvalid_i & mem_err_i: err_o pulse, shadows discarded, pmp_addr_o unchanged -> IDLE.
//   - COMMIT: pmp_addr_o[0..N_CTX_WORDS-1] = shadow in one cycle; done_o pulse that same cycle -> IDLE.
// - Latency, zero-wait bus (gnt same cycle as req, rvalid one cycle later):
//   - 2*N_CTX_WORDS + 2 cycles from pulse to done_o.
//   - busy_o is high from the cycle after the pulse through the COMMIT cycle.
// - switch_req_i while busy_o: ignored, no queueing. The scheduler must wait for done_o or err_o.
// - CSR writes apply to the active entry the cycle after csr_we_i, in any state.
//   - CSR write and COMMIT in the same cycle to the same entry < N_CTX_WORDS: COMMIT wins.
//   - Entries >= N_CTX_WORDS are CSR-writable only.
// - Address arithmetic is 32-bit modulo; wrap past 0xFFFF_FFFC is not checked.
// - Reset mid-load: all state and outputs return to reset values. Any outstanding bus response arriving after reset is ignored in IDLE.
// - Stray mem_rvalid_i outside WAIT: ignored.
//
// STRUCTURE
// - Into riscv_defines: FSM enum ctx_state_t and descriptor word index constants. Reuse the existing PMP_* entry indices.
// - No sub-module. Shadow array and active array are both local to this file.
//
// TESTING
// 1. Zero-wait bus, task 2, base 0x0010_0000:
//    - reads issued at 0x0010_0080..0x0010_00A4 in order;
//    - done_o at cycle 22 after the pulse;
//    - pmp_addr_o[0..9] equal the read data.
// 2. Gnt delayed 3 cycles on word 4: mem_addr_o and mem_req_o stay stable across the stall; final config correct.
// 3. mem_err_i on word 7:
//    - err_o pulse; pmp_addr_o keeps the previous task's values bit-exact;
//    - busy_o drops; a new switch succeeds.
// 4. Second switch_req_i while busy: ignored; exactly N_CTX_WORDS reads are issued; one done_o.
// 5. CSR write to entry 3 in the COMMIT cycle: shadow value wins. CSR write to entry 12 during a load: applied.
// 6. rst_n asserted at word 5:
//    - all pmp_addr_o = 0, mem_req_o = 0;
//    - a late rvalid is ignored;
//    - the next load completes correctly.

Source files
------------

// File: rtl/riscv_smartv_ctx_loader_pkg.sv
// Shared types for the SMART-V context loader: FSM states, descriptor word layout
// and the descriptor address helper.
package riscv_smartv_ctx_loader_pkg;

  typedef enum logic [1:0] {
    CTX_IDLE,
    CTX_REQ,
    CTX_WAIT,
    CTX_COMMIT
  } ctx_state_t;

  // Word order inside one task descriptor; word i lands in pmp entry i.
  typedef enum logic [3:0] {
    DESC_CODE_LO,
    DESC_CODE_HI,
    DESC_DATA_LO,
    DESC_DATA_HI,
    DESC_LIB_LO,
    DESC_LIB_HI,
    DESC_PERIPH_MASK,
    DESC_BITBAND_MASK,
    DESC_BITBAND_REG0,
    DESC_BITBAND_REG1
  } desc_word_t;

  localparam int unsigned DESC_WORD_BYTES = 4;

  function automatic logic [31:0] desc_base(input logic [31:0] table_base,
                                            input logic [31:0] task_id,
                                            input int unsigned stride_log2);
    return table_base + (task_id << stride_log2);
  endfunction

endpackage

// File: rtl/riscv_smartv_ctx_loader_if.sv
// Single-outstanding read port between the context loader and descriptor memory.
interface riscv_smartv_ctx_loader_if;

  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (output req, addr, input gnt, rvalid, rdata, err);
  modport slave  (input req, addr, output gnt, rvalid, rdata, err);

endinterface

// File: rtl/riscv_smartv_ctx_loader.sv
// Loads a task's region descriptor into shadow registers and commits it to the
// active pmp_addr vector in a single cycle, stalling the core meanwhile.
module riscv_smartv_ctx_loader
  import riscv_smartv_ctx_loader_pkg::*;
#(
  parameter int N_PMP_ENTRIES    = 16,
  parameter int N_CTX_WORDS      = 10,
  parameter int TASK_ID_W        = 4,
  parameter int DESC_STRIDE_LOG2 = 6
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   switch_req_i,
  input  logic [TASK_ID_W-1:0]                   task_id_i,
  input  logic [31:0]                            table_base_i,
  output logic                                   busy_o,
  output logic                                   core_stall_o,
  output logic                                   done_o,
  output logic                                   err_o,
  riscv_smartv_ctx_loader_if.master              mem,
  input  logic                                   csr_we_i,
  input  logic [$clog2(N_PMP_ENTRIES)-1:0]       csr_idx_i,
  input  logic [31:0]                            csr_wdata_i,
  output logic [N_PMP_ENTRIES-1:0][31:0]         pmp_addr_o
);

  localparam int K_W = (N_CTX_WORDS > 1) ? $clog2(N_CTX_WORDS) : 1;

  ctx_state_t     state_q, state_d;
  logic [K_W-1:0] k_q;
  logic [31:0]    addr_q;
  logic [31:0]    shadow_q [N_CTX_WORDS];
  logic           last_word;
  logic           rd_ok;
  logic           rd_err;

  assign last_word    = (k_q == K_W'(N_CTX_WORDS - 1));
  assign rd_ok        = (state_q == CTX_WAIT) && mem.rvalid && !mem.err;
  assign rd_err       = (state_q == CTX_WAIT) && mem.rvalid &&  mem.err;

  assign mem.req      = (state_q == CTX_REQ);
  assign mem.addr     = addr_q;
  assign busy_o       = (state_q != CTX_IDLE);
  assign core_stall_o = busy_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= CTX_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CTX_IDLE:   if (switch_req_i) state_d = CTX_REQ;
      CTX_REQ:    if (mem.gnt) state_d = CTX_WAIT;
      CTX_WAIT: begin
        if (rd_err)     state_d = CTX_IDLE;
        else if (rd_ok) state_d = last_word ? CTX_COMMIT : CTX_REQ;
      end
      CTX_COMMIT: state_d = CTX_IDLE;
      default:    state_d = CTX_IDLE;
    endcase
  end

  // Address and word counter advance only on a good response, so a stalled
  // grant leaves the request untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q    <= '0;
      addr_q <= '0;
      done_o <= 1'b0;
      err_o  <= 1'b0;
    end else begin
      done_o <= (state_q == CTX_COMMIT);
      err_o  <= rd_err;
      if ((state_q == CTX_IDLE) && switch_req_i) begin
        k_q    <= '0;
        addr_q <= desc_base(table_base_i, 32'(task_id_i), DESC_STRIDE_LOG2);
      end else if (rd_ok && !last_word) begin
        k_q    <= k_q + 1'b1;
        addr_q <= addr_q + 32'(DESC_WORD_BYTES);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rd_ok) shadow_q[k_q] <= mem.rdata;
  end

  // Commit is written after the CSR write so it takes priority on a collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pmp_addr_o <= '0;
    end else begin
      if (csr_we_i) pmp_addr_o[csr_idx_i] <= csr_wdata_i;
      if (state_q == CTX_COMMIT) begin
        for (int i = 0; i < N_CTX_WORDS; i++) pmp_addr_o[i] <= shadow_q[i];
      end
    end
  end

endmodule

// File: tb/tb_riscv_smartv_ctx_loader.sv
// Scoreboard bench for the context loader: a bus responder serves descriptor reads,
// monitors pop expected reads and done/err events and compare them.
module tb_riscv_smartv_ctx_loader;

  typedef struct packed {
    logic              is_err;
    logic [31:0]       exp_cyc;
    logic [15:0][31:0] cfg;
  } evt_t;

  logic              clk;
  logic              rst_n;
  logic              switch_req;
  logic [3:0]        task_id;
  logic [31:0]       table_base;
  logic              busy, core_stall, done, err;
  logic              csr_we;
  logic [3:0]        csr_idx;
  logic [31:0]       csr_wdata;
  logic [15:0][31:0] pmp;

  riscv_smartv_ctx_loader_if mem_if ();

  riscv_smartv_ctx_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .switch_req_i (switch_req),
    .task_id_i    (task_id),
    .table_base_i (table_base),
    .busy_o       (busy),
    .core_stall_o (core_stall),
    .done_o       (done),
    .err_o        (err),
    .mem          (mem_if),
    .csr_we_i     (csr_we),
    .csr_idx_i    (csr_idx),
    .csr_wdata_i  (csr_wdata),
    .pmp_addr_o   (pmp)
  );

  int          n_checks = 0;
  int          n_err    = 0;
  int          cyc      = 0;
  logic [31:0] exp_addr [$];
  evt_t        exp_evt  [$];

  // Stimulus-owned knobs read by the responder
  logic [31:0] cur_base   = 32'h0;
  logic [15:0] seed       = 16'h0;
  int          stall_word = -1;
  int          err_word   = -1;

  logic [15:0][31:0] model = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Responder: grant at the negedge of the request cycle, data one cycle later.
  logic        pend = 1'b0;
  logic [31:0] pend_data = 32'h0;
  logic        pend_err = 1'b0;
  int          waited = 0;
  always @(negedge clk) begin
    int w;
    mem_if.gnt    = 1'b0;
    mem_if.rvalid = 1'b0;
    mem_if.err    = 1'b0;
    mem_if.rdata  = 32'hFFFF_FFFF;
    if (pend) begin
      mem_if.rvalid = 1'b1;
      mem_if.rdata  = pend_data;
      mem_if.err    = pend_err;
      pend          = 1'b0;
    end
    if (mem_if.req === 1'b1) begin
      w = int'((mem_if.addr - cur_base) >> 2);
      if (w == stall_word && waited < 3) begin
        waited++;
      end else begin
        mem_if.gnt = 1'b1;
        waited     = 0;
        pend       = 1'b1;
        pend_data  = {seed, mem_if.addr[15:0]};
        pend_err   = (w == err_word);
      end
    end
  end

  // Monitor: read order, request stability under stall, done/err events.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr  = 32'h0;
  always @(negedge clk) begin
    evt_t ev;
    #1;
    if (prev_stall && rst_n) begin
      chk("req_hold", 32'(mem_if.req), 32'd1);
      chk("addr_hold", mem_if.addr, prev_addr);
    end
    prev_stall = (mem_if.req === 1'b1) && !mem_if.gnt;
    prev_addr  = mem_if.addr;
    if (mem_if.req === 1'b1 && mem_if.gnt) begin
      if (exp_addr.size() == 0) begin
        n_checks++; n_err++;
        $display("FAIL unexpected_read: addr %h, none expected (cycle %0d)", mem_if.addr, cyc);
      end else begin
        chk("read_addr", mem_if.addr, exp_addr.pop_front());
      end
    end
    if (done === 1'b1 || err === 1'b1) begin
      if (exp_evt.size() == 0) begin
        n_checks++; n_err++;
        $display("FAIL unexpected_event: done %b err %b, none expected (cycle %0d)", done, err, cyc);
      end else begin
        ev = exp_evt.pop_front();
        chk("evt_err", 32'(err), 32'(ev.is_err));
        chk("evt_done", 32'(done), 32'(!ev.is_err));
        chk("busy_after_evt", 32'(busy), 32'd0);
        if (ev.exp_cyc != 0) chk("latency", 32'(cyc), ev.exp_cyc);
        for (int i = 0; i < 16; i++) chk($sformatf("pmp[%0d]", i), pmp[i], ev.cfg[i]);
      end
    end
  end

  function automatic logic [15:0][31:0] load_cfg(input logic [15:0][31:0] prev,
                                                 input logic [15:0] sd,
                                                 input logic [31:0] base);
    logic [15:0][31:0] c;
    logic [31:0]       a;
    c = prev;
    for (int k = 0; k < 10; k++) begin
      a    = base + 32'(4 * k);
      c[k] = {sd, a[15:0]};
    end
    return c;
  endfunction

  task automatic do_switch(input logic [3:0] tid, input logic [31:0] tbase,
                           input logic [31:0] ebase, input logic [15:0] sd,
                           input int nwords, output int pc);
    @(negedge clk);
    task_id    = tid;
    table_base = tbase;
    switch_req = 1'b1;
    cur_base   = ebase;
    seed       = sd;
    for (int k = 0; k < nwords; k++) exp_addr.push_back(ebase + 32'(4 * k));
    pc = cyc;
    @(negedge clk);
    switch_req = 1'b0;
  endtask

  task automatic push_evt(input logic is_err, input int ecyc, input logic [15:0][31:0] cfg);
    evt_t ev;
    ev.is_err  = is_err;
    ev.exp_cyc = 32'(ecyc);
    ev.cfg     = cfg;
    exp_evt.push_back(ev);
  endtask

  task automatic drain(input int max);
    int t = 0;
    while ((exp_evt.size() != 0 || exp_addr.size() != 0) && t < max) begin
      @(negedge clk); #2;
      t++;
    end
    chk("evt_drained", 32'(exp_evt.size()), 32'd0);
    chk("reads_drained", 32'(exp_addr.size()), 32'd0);
  endtask

  task automatic csr_write(input logic [3:0] idx, input logic [31:0] data);
    @(negedge clk);
    csr_we = 1'b1; csr_idx = idx; csr_wdata = data;
    @(negedge clk);
    csr_we = 1'b0;
  endtask

  initial begin
    int pc;
    bit found;
    rst_n = 1'b0; switch_req = 1'b0; task_id = '0; table_base = '0;
    csr_we = 1'b0; csr_idx = '0; csr_wdata = '0;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_stall", 32'(core_stall), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_req", 32'(mem_if.req), 32'd0);
    chk("rst_addr", mem_if.addr, 32'h0);
    chk("rst_pmp0", pmp[0], 32'h0);
    chk("rst_pmp15", pmp[15], 32'h0);
    rst_n = 1'b1;

    // 1: zero-wait load of task 2
    do_switch(4'd2, 32'h0010_0000, 32'h0010_0080, 16'h1111, 10, pc);
    #3 chk("busy_after_pulse", 32'(busy), 32'd1);
    chk("stall_after_pulse", 32'(core_stall), 32'd1);
    model = load_cfg(model, 16'h1111, 32'h0010_0080);
    push_evt(1'b0, pc + 22, model);
    drain(60);
    chk("t1_pmp0", pmp[0], 32'h1111_0080);
    chk("t1_pmp9", pmp[9], 32'h1111_00A4);

    // 2: grant delayed 3 cycles on word 4
    stall_word = 4;
    do_switch(4'd5, 32'h2000_0000, 32'h2000_0140, 16'h2222, 10, pc);
    model = load_cfg(model, 16'h2222, 32'h2000_0140);
    push_evt(1'b0, pc + 25, model);
    drain(60);
    stall_word = -1;
    chk("t2_pmp4", pmp[4], 32'h2222_0150);

    // 3: bus error on word 7 keeps the previous config, then a clean load
    err_word = 7;
    do_switch(4'd1, 32'h0000_4000, 32'h0000_4040, 16'h3333, 8, pc);
    push_evt(1'b1, 0, model);
    drain(60);
    err_word = -1;
    chk("t3_pmp7_kept", pmp[7], 32'h2222_015C);
    do_switch(4'd15, 32'hFFFF_0000, 32'hFFFF_03C0, 16'h3434, 10, pc);
    model = load_cfg(model, 16'h3434, 32'hFFFF_03C0);
    push_evt(1'b0, pc + 22, model);
    drain(60);

    // 4: second pulse while busy is dropped
    do_switch(4'd0, 32'h0000_1000, 32'h0000_1000, 16'h4444, 10, pc);
    model = load_cfg(model, 16'h4444, 32'h0000_1000);
    push_evt(1'b0, pc + 22, model);
    repeat (3) @(negedge clk);
    task_id = 4'd7; table_base = 32'h0800_0000; switch_req = 1'b1;
    @(negedge clk);
    switch_req = 1'b0;
    drain(60);
    repeat (30) @(negedge clk);
    #2 chk("t4_no_extra_reads", 32'(exp_addr.size()), 32'd0);
    chk("t4_idle", 32'(busy), 32'd0);

    // 5: CSR to entry 12 mid-load applies; CSR to entry 3 in COMMIT loses
    do_switch(4'd3, 32'h0003_0000, 32'h0003_00C0, 16'h5555, 10, pc);
    csr_write(4'd12, 32'h1234_5678);
    model[12] = 32'h1234_5678;
    model = load_cfg(model, 16'h5555, 32'h0003_00C0);
    push_evt(1'b0, pc + 22, model);
    while (cyc < pc + 20) @(negedge clk);
    csr_write(4'd3, 32'hDEAD_BEEF);
    drain(60);
    chk("t5_pmp3_commit_wins", pmp[3], 32'h5555_00CC);
    chk("t5_pmp12_csr", pmp[12], 32'h1234_5678);
    csr_write(4'd3, 32'hCAFE_F00D);
    #2 chk("t5_pmp3_csr_idle", pmp[3], 32'hCAFE_F00D);
    model[3] = 32'hCAFE_F00D;

    // 6: reset while word 5 is outstanding
    do_switch(4'd4, 32'h0100_0000, 32'h0100_0100, 16'h6666, 6, pc);
    found = 1'b0;
    for (int t = 0; t < 50 && !found; t++) begin
      @(negedge clk); #2;
      if (mem_if.req === 1'b1 && mem_if.gnt && mem_if.addr == 32'h0100_0114) found = 1'b1;
    end
    chk("t6_word5_granted", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_req", 32'(mem_if.req), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 16; i++) chk($sformatf("t6_rst_pmp[%0d]", i), pmp[i], 32'h0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk); #3;
    chk("t6_late_busy", 32'(busy), 32'd0);
    chk("t6_late_req", 32'(mem_if.req), 32'd0);
    chk("t6_late_pmp5", pmp[5], 32'h0);
    chk("t6_reads_left", 32'(exp_addr.size()), 32'd0);
    model = '0;
    do_switch(4'd4, 32'h0100_0000, 32'h0100_0100, 16'h6767, 10, pc);
    model = load_cfg(model, 16'h6767, 32'h0100_0100);
    push_evt(1'b0, pc + 22, model);
    drain(60);
    chk("t6_pmp9", pmp[9], 32'h6767_0124);

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", n_err);
    $fatal(1, "watchdog");
  end

endmodule
